// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one imem read at a time
// and hands each fetched word to decode over a valid/ready handshake.
module ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_OUT, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            hp_q, hp_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            iv_q, iv_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] redir;
  logic            unused_lsb;

  assign redir      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    hp_d     = hp_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    iv_d     = iv_q;
    halted_d = halted_q;
    unique case (state_q)
      S_IDLE: state_d = halt ? S_HALT : S_REQ;
      S_REQ: begin
        // An accepted request with halt still owes us a response.
        if (halt) begin
          if (imem_req_ready) begin
            hp_d    = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_HALT;
          end
        end else begin
          if (redirect_valid) pc_d = redir;
          if (imem_req_ready) begin
            state_d = S_WAIT;
            drop_d  = redirect_valid;
          end
        end
      end
      S_WAIT: begin
        if (halt || hp_q) begin
          if (imem_rsp_valid) state_d = S_HALT;
          else hp_d = 1'b1;
        end else if (redirect_valid) begin
          pc_d = redir;
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q) begin
            state_d = S_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            ipc_d   = pc_q;
            iv_d    = 1'b1;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (redirect_valid) begin
          iv_d    = 1'b0;
          pc_d    = redir;
          state_d = S_REQ;
        end else if (inst_ready) begin
          iv_d    = 1'b0;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_HALT) begin
      iv_d     = 1'b0;
      halted_d = 1'b1;
      hp_d     = 1'b0;
      drop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      hp_q     <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
      iv_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      hp_q     <= hp_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      iv_q     <= iv_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = iv_q;
  assign inst           = inst_q;
  assign inst_pc        = ipc_q;
  assign halted         = halted_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the NPC core. Produces the 32-bit instruction stream consumed by the decode stage.
- Holds the PC and issues one read at a time to instruction memory over a valid/ready request channel plus a response-valid channel.
- Presents each fetched instruction and its PC to decode with a valid/ready handshake.
- Accepts PC redirects from execute and a halt (ebreak) from decode.

Parameters:
- XLEN, 64, width of PC and memory address.
- RESET_PC, 64'h8000_0000, PC loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  read data valid.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction this cycle.
- inst  out  32  instruction word.
- inst_pc  out  XLEN  PC of inst.
- redirect_valid  in  1  load new PC.
- redirect_pc  in  XLEN  redirect target.
- halt  in  1  ebreak seen; stop fetching.
- halted  out  1  fetch stopped.

Behaviour:
- Reset values (asserted immediately and asynchronously on rst):
  - state = IDLE, pc = RESET_PC, drop = 0, halt_pend = 0.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - inst_valid = 0, inst = 0, inst_pc = 0, halted = 0.
- imem_req_addr always equals pc. pc[1:0] is always 0; redirect_pc[1:0] is ignored.
- At most one outstanding memory request. imem_rsp_valid is ignored outside WAIT.
- States:
  - IDLE: one cycle after reset release -> REQ.
  - REQ: imem_req_valid = 1. Addr/valid held stable until imem_req_ready = 1, then -> WAIT.
  - WAIT: on imem_rsp_valid:
    - drop = 1: discard data, clear drop, -> REQ.
    - drop = 0: latch inst = imem_rsp_data, inst_pc = pc, inst_valid = 1 on the next edge, -> OUT.
    - Minimum latency from response to inst_valid is 1 cycle.
  - OUT: inst/inst_pc/inst_valid held stable while inst_ready = 0. On inst_ready = 1: inst_valid <= 0, pc <= pc + 4 (mod 2^XLEN), -> REQ.
  - HALT: imem_req_valid = 0, inst_valid = 0, halted = 1. Exits only on rst.
- Redirect (lower priority than halt):
  - REQ, req_ready = 0: pc <= redirect_pc; stay REQ. The new address is presented next cycle, with no drop.
  - REQ, req_ready = 1 in the same cycle: request at the old pc is accepted; pc <= redirect_pc, drop <= 1, -> WAIT.
  - WAIT: pc <= redirect_pc, drop <= 1. If imem_rsp_valid arrives the same cycle, that response is discarded and the state goes to REQ.
  - OUT: inst_valid <= 0, pc <= redirect_pc, -> REQ, regardless of inst_ready. The pc + 4 increment is suppressed.
- Halt:
  - In IDLE/REQ/OUT: -> HALT next edge. If the request is accepted in the same REQ cycle, it is treated as in WAIT.
  - In WAIT: halt_pend <= 1. On the response, discard it and go -> HALT. A halt in the same cycle as the response goes directly -> HALT.
  - halted rises on the edge that enters HALT.
- Reset mid-transaction: all state clears immediately. A stale response after reset release arrives outside WAIT and is ignored.

Test Plan:
1. Reset, memory with req_ready = 1 and rsp 1 cycle after accept, inst_ready = 1, words 0x00100093/0x00208113/0x00100073 -> addrs 0x80000000, 0x80000004, 0x80000008 in order; inst/inst_pc match pairwise.
2. inst_ready low for 3 cycles in OUT -> inst = 0x00100093 and inst_pc = 0x80000000 stable, imem_req_valid = 0; the next request goes to 0x80000004 only after the handshake.
3. Redirect to 0x80000100 in WAIT, rsp 0xDEADBEEF two cycles later -> word discarded, inst_valid stays 0, next req addr 0x80000100. Repeat with redirect and rsp in the same cycle -> same result.
4. req_ready held 0 in REQ, redirect to 0x80000200 -> imem_req_addr switches to 0x80000200 next cycle; the returned word is delivered, not dropped.
5. halt asserted in WAIT -> pending response consumed and not presented, halted = 1, no further imem_req_valid for 10 cycles. rst then restarts fetch at 0x80000000.
6. Redirect to 0xFFFFFFFFFFFFFFFC, fetch and consume -> next addr 0x0. Separately, rst pulsed mid-WAIT -> outputs at reset values in the same cycle, the stale rsp is ignored, and fetch restarts at RESET_PC.
